seven_segment_capture: RTL and testbench

//  Receive-side counterpart of the multiplexed 7-segment display driver: samples an active-low

---
 rtl/seven_segment_capture.sv | 171 +++++++++++++++++
 tb/tb_seven_segment_capture.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seven_segment_capture.sv
// Receive-side monitor for a multiplexed 7-segment display: synchronizes digit selects and
// segments, waits for each (select, pattern) pair to settle, and decodes it back to a hex nibble.
module seven_segment_capture #(
  parameter int STABLE_CNT  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  grounds,
  input  logic [6:0]  display,
  input  logic        clr_err,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic [3:0]  blank,
  output logic        frame_done,
  output logic        err_select,
  output logic        err_pattern
);

  localparam int CW = $clog2(STABLE_CNT + 1);

  typedef enum logic [1:0] {IDLE, DWELL, HELD} state_t;

  state_t state, state_d;

  logic [SYNC_STAGES-1:0][3:0] g_sync;
  logic [SYNC_STAGES-1:0][6:0] d_sync;
  logic [SYNC_STAGES-1:0]      primed;
  logic [3:0]                  gs;
  logic [6:0]                  ds;

  logic [CW-1:0] cnt, cnt_d;
  logic [1:0]    lat_idx;
  logic [6:0]    lat_pat;
  logic [3:0]    frame_mask, mask_next;

  logic [2:0] nz;
  logic [1:0] idx;
  logic       sel_ok, multi, same, load, inc, capture;
  logic [4:0] dec;
  logic       hit, is_blank, mark, cap_bad, frame_all;

  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    case (p)
      7'h7E:   seg_decode = 5'h10;
      7'h30:   seg_decode = 5'h11;
      7'h6D:   seg_decode = 5'h12;
      7'h79:   seg_decode = 5'h13;
      7'h33:   seg_decode = 5'h14;
      7'h5B:   seg_decode = 5'h15;
      7'h5F:   seg_decode = 5'h16;
      7'h70:   seg_decode = 5'h17;
      7'h7F:   seg_decode = 5'h18;
      7'h7B:   seg_decode = 5'h19;
      7'h77:   seg_decode = 5'h1A;
      7'h1F:   seg_decode = 5'h1B;
      7'h4E:   seg_decode = 5'h1C;
      7'h3D:   seg_decode = 5'h1D;
      7'h4F:   seg_decode = 5'h1E;
      7'h47:   seg_decode = 5'h1F;
      default: seg_decode = 5'h00;
    endcase
  endfunction

  // primed marks when the synchronizer holds real pin samples, so its all-zero reset
  // contents are never mistaken for a multi-select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_sync <= '0;
      d_sync <= '0;
      primed <= '0;
    end else begin
      g_sync <= {g_sync[SYNC_STAGES-2:0], grounds};
      d_sync <= {d_sync[SYNC_STAGES-2:0], display};
      primed <= {primed[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign gs = g_sync[SYNC_STAGES-1];
  assign ds = d_sync[SYNC_STAGES-1];

  always_comb begin
    nz  = '0;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (!gs[i]) begin
        nz  = nz + 3'd1;
        idx = 2'(i);
      end
    end
  end

  assign sel_ok = primed[SYNC_STAGES-1] && (nz == 3'd1);
  assign multi  = primed[SYNC_STAGES-1] && (nz > 3'd1);
  assign same   = (idx == lat_idx) && (ds == lat_pat);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    load    = 1'b0;
    inc     = 1'b0;
    case (state)
      IDLE: if (sel_ok) load = 1'b1;
      DWELL: begin
        if (!sel_ok) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (same) inc = 1'b1;
        else load = 1'b1;
      end
      HELD: begin
        if (!sel_ok) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!same) load = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      cnt_d   = CW'(1);
      state_d = DWELL;
    end
    if (inc && cnt != CW'(STABLE_CNT)) cnt_d = cnt + CW'(1);
    // The sample that brings the count to STABLE_CNT is the capture sample.
    capture = (load || inc) && (cnt_d == CW'(STABLE_CNT));
    if (capture) state_d = HELD;
  end

  assign dec       = seg_decode(ds);
  assign hit       = dec[4];
  assign is_blank  = (ds == 7'h00);
  assign mark      = capture && (hit || is_blank);
  assign cap_bad   = capture && !hit && !is_blank;
  assign mask_next = frame_mask | (mark ? (4'b0001 << idx) : 4'b0000);
  assign frame_all = (mask_next == 4'b1111);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_idx     <= '0;
      lat_pat     <= '0;
      frame_mask  <= '0;
      digits      <= '0;
      digit_valid <= '0;
      blank       <= '0;
      frame_done  <= 1'b0;
      err_select  <= 1'b0;
      err_pattern <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (load) begin
        lat_idx <= idx;
        lat_pat <= ds;
      end
      if (capture && hit) begin
        digits[{idx, 2'b00} +: 4] <= dec[3:0];
        digit_valid[idx]          <= 1'b1;
        blank[idx]                <= 1'b0;
      end
      if (capture && is_blank) blank[idx] <= 1'b1;
      frame_done <= frame_all;
      frame_mask <= frame_all ? 4'b0000 : mask_next;
      // A new error event outranks a simultaneous clear.
      err_select  <= multi   ? 1'b1 : (clr_err ? 1'b0 : err_select);
      err_pattern <= cap_bad ? 1'b1 : (clr_err ? 1'b0 : err_pattern);
    end
  end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture: vector table for the digit sweep plus
// hand-written sequences for latency, glitch, error and reset corners.
module tb_seven_segment_capture;

  logic        clk;
  logic        rst;
  logic [3:0]  grounds;
  logic [6:0]  display;
  logic        clr_err;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic [3:0]  blank;
  logic        frame_done;
  logic        err_select;
  logic        err_pattern;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  logic watch8 = 1'b0;
  logic saw8   = 1'b0;

  typedef struct {
    logic [3:0]  g;
    logic [6:0]  d;
    logic        fd;
    logic [15:0] dig;
    logic [3:0]  vld;
  } vec_t;

  vec_t vecs[4];

  seven_segment_capture #(.STABLE_CNT(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .grounds(grounds), .display(display), .clr_err(clr_err),
    .digits(digits), .digit_valid(digit_valid), .blank(blank), .frame_done(frame_done),
    .err_select(err_select), .err_pattern(err_pattern)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (watch8 && digits[3:0] == 4'h8) saw8 = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0] = '{g: 4'b1110, d: 7'h30, fd: 1'b0, dig: 16'h0001, vld: 4'b0001};
    vecs[1] = '{g: 4'b1101, d: 7'h5B, fd: 1'b0, dig: 16'h0051, vld: 4'b0011};
    vecs[2] = '{g: 4'b1011, d: 7'h77, fd: 1'b0, dig: 16'h0A51, vld: 4'b0111};
    vecs[3] = '{g: 4'b0111, d: 7'h47, fd: 1'b1, dig: 16'hFA51, vld: 4'b1111};

    rst = 1'b1; grounds = 4'b1111; display = 7'h00; clr_err = 1'b0;

    // Reset with random pins
    for (int i = 0; i < 4; i++) begin
      grounds = 4'($urandom_range(0, 15));
      display = 7'($urandom_range(0, 127));
      tick();
    end
    check("rst_digits", 32'(digits), 32'h0);
    check("rst_valid", 32'(digit_valid), 32'h0);
    check("rst_blank", 32'(blank), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    check("rst_err_select", 32'(err_select), 32'h0);
    check("rst_err_pattern", 32'(err_pattern), 32'h0);
    grounds = 4'b1111; display = 7'h00;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check("post_rst_err_select", 32'(err_select), 32'h0);

    // Single digit: exact latency of 6 edges
    grounds = 4'b1110; display = 7'h79;
    repeat (5) tick();
    check("lat_edge5_digits", 32'(digits), 32'h0);
    check("lat_edge5_valid", 32'(digit_valid), 32'h0);
    tick();
    check("lat_edge6_digits", 32'(digits), 32'h0003);
    check("lat_edge6_valid", 32'(digit_valid), 32'h1);
    repeat (10) tick();
    check("hold_digits", 32'(digits), 32'h0003);
    check("hold_no_frame", 32'(fd_cnt), 32'd0);

    // Sweep all four digits from the table
    for (int i = 0; i < 4; i++) begin
      grounds = vecs[i].g; display = vecs[i].d;
      repeat (5) tick();
      check($sformatf("sweep%0d_fd_early", i), 32'(frame_done), 32'h0);
      tick();
      check($sformatf("sweep%0d_fd_capture", i), 32'(frame_done), 32'(vecs[i].fd));
      repeat (2) tick();
      check($sformatf("sweep%0d_digits", i), 32'(digits), 32'(vecs[i].dig));
      check($sformatf("sweep%0d_valid", i), 32'(digit_valid), 32'(vecs[i].vld));
    end
    check("sweep_frame_pulses", 32'(fd_cnt), 32'd1);

    // Glitch: 3 samples of 8 then 9 settles
    grounds = 4'b1110; display = 7'h7F; watch8 = 1'b1;
    repeat (3) tick();
    display = 7'h7B;
    repeat (8) tick();
    watch8 = 1'b0;
    check("glitch_never8", 32'(saw8), 32'h0);
    check("glitch_digits", 32'(digits), 32'hFA59);

    // Errors
    grounds = 4'b1100; display = 7'h7B;
    repeat (4) tick();
    check("multi_err_select", 32'(err_select), 32'h1);
    check("multi_digits", 32'(digits), 32'hFA59);
    grounds = 4'b1110; display = 7'h55;
    repeat (8) tick();
    check("badpat_err_pattern", 32'(err_pattern), 32'h1);
    check("badpat_digits", 32'(digits), 32'hFA59);
    grounds = 4'b1111; display = 7'h00;
    repeat (4) tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_err_select", 32'(err_select), 32'h0);
    check("clr_err_pattern", 32'(err_pattern), 32'h0);
    grounds = 4'b1110; display = 7'h55;
    repeat (5) tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("set_wins_err_pattern", 32'(err_pattern), 32'h1);
    repeat (3) tick();
    check("sticky_err_pattern", 32'(err_pattern), 32'h1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_alone_err_pattern", 32'(err_pattern), 32'h0);
    repeat (3) tick();
    check("held_no_recapture", 32'(err_pattern), 32'h0);

    // Blank on digit 2
    grounds = 4'b1011; display = 7'h00;
    repeat (8) tick();
    check("blank_mask", 32'(blank), 32'h4);
    check("blank_digits", 32'(digits), 32'hFA59);
    check("blank_valid", 32'(digit_valid), 32'hF);

    // Reset during dwell
    grounds = 4'b1101; display = 7'h30;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    check("async_rst_digits", 32'(digits), 32'h0);
    check("async_rst_valid", 32'(digit_valid), 32'h0);
    check("async_rst_blank", 32'(blank), 32'h0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    check("resume_edge5_valid", 32'(digit_valid), 32'h0);
    tick();
    check("resume_edge6_digits", 32'(digits), 32'h0010);
    check("resume_edge6_valid", 32'(digit_valid), 32'h2);
    check("total_frame_pulses", 32'(fd_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
